sde_c2h_stream_arb: RTL and testbench

- Packet-granular round-robin arbiter that shares the single SDE C2H AXI-Stream ingress between NUM_SRC CL packet sources (for example the internal packet generator, the loopback path and the stream BFM).
- Sits between the sources and the SDE C2H stream slave.
- Once a source is granted, it owns the stream until its tlast beat is accepted.
- Provides per-source enable, a global arbitration enable, and per-source packet counters for host readback over OCL.

---
 rtl/sde_c2h_stream_arb.sv | 153 +++++++++++++++
 tb/tb_sde_c2h_stream_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sde_c2h_stream_arb.sv
// Packet-granular round-robin arbiter sharing the SDE C2H AXI-Stream ingress
// between NUM_SRC sources, with per-source completed-packet counters.
module sde_c2h_stream_arb #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              arb_en,
    input  logic [NUM_SRC-1:0]                src_en,
    input  logic                              cnt_clr,
    input  logic [NUM_SRC-1:0]                s_axis_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC*USER_WIDTH-1:0]     s_axis_tuser,
    input  logic [NUM_SRC-1:0]                s_axis_tlast,
    output logic [NUM_SRC-1:0]                s_axis_tready,
    output logic                              m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [USER_WIDTH-1:0]             m_axis_tuser,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]        cur_src,
    output logic                              busy,
    output logic [NUM_SRC*CNT_WIDTH-1:0]      pkt_cnt
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       cur_src_q, cur_src_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_SRC];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_SRC];

    logic [NUM_SRC-1:0]     req_s;
    logic                   found_s;
    logic [IDX_W-1:0]       win_s;
    logic                   last_xfer_s;

    // State register, round-robin pointer, grant and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cur_src_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_src_q <= cur_src_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next-state: round-robin winner search, packet completion, counters.
    always_comb begin
        req_s       = s_axis_tvalid & src_en & {NUM_SRC{arb_en}};
        found_s     = 1'b0;
        win_s       = '0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_src_d   = cur_src_q;
        last_xfer_s = 1'b0;

        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found_s && req_s[(int'(ptr_q) + k) % NUM_SRC]) begin
                found_s = 1'b1;
                win_s   = IDX_W'((int'(ptr_q) + k) % NUM_SRC);
            end else begin
                found_s = found_s;
            end
        end

        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d   = PASS;
                    cur_src_d = win_s;
                end else begin
                    state_d   = IDLE;
                end
            end
            PASS: begin
                last_xfer_s = s_axis_tvalid[cur_src_q] & m_axis_tready & s_axis_tlast[cur_src_q];
                if (last_xfer_s) begin
                    state_d = IDLE;
                    ptr_d   = (cur_src_q == IDX_W'(NUM_SRC - 1)) ? '0 : cur_src_q + IDX_W'(1);
                end else begin
                    state_d = PASS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear on the same cycle as a packet completion leaves the counter at zero.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (last_xfer_s && (cur_src_q == IDX_W'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Output decode: zero-latency mux of the granted source while in PASS.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            PASS: begin
                m_axis_tvalid            = s_axis_tvalid[cur_src_q];
                m_axis_tdata             = s_axis_tdata[int'(cur_src_q)*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep             = s_axis_tkeep[int'(cur_src_q)*KEEP_W +: KEEP_W];
                m_axis_tuser             = s_axis_tuser[int'(cur_src_q)*USER_WIDTH +: USER_WIDTH];
                m_axis_tlast             = s_axis_tlast[cur_src_q];
                s_axis_tready[cur_src_q] = m_axis_tready;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign cur_src = cur_src_q;
    assign busy    = (state_q == PASS);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

endmodule

// File: tb/tb_sde_c2h_stream_arb.sv
// Self-checking bench for sde_c2h_stream_arb: directed and randomized packet
// traffic checked against a transaction-level reference model.
module tb_sde_c2h_stream_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 64;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              arb_en;
    logic [N-1:0]      src_en;
    logic              cnt_clr;
    logic [N-1:0]      s_axis_tvalid;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N*UW-1:0]   s_axis_tuser;
    logic [N-1:0]      s_axis_tlast;
    logic [N-1:0]      s_axis_tready;
    logic              m_axis_tvalid;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [1:0]        cur_src;
    logic              busy;
    logic [N*CW-1:0]   pkt_cnt;

    sde_c2h_stream_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .src_en(src_en), .cnt_clr(cnt_clr),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .cur_src(cur_src), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;
    int nfail = 0;

    // Reference model: owner of the stream (-1 = none), pointer, counters.
    int owner, ptr, last_src;
    int cnt [N];
    // Source generators.
    int beat [N];
    int len [N];
    int pkt [N];
    int pkts_left [N];
    bit hold [N];
    int xfer_cnt [N];
    int grant_log [$];
    bit rand_mode   = 1'b0;
    bit toggle_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int i);
        return {8'(i), 8'(pkt[i]), 16'(beat[i])};
    endfunction

    function automatic logic [UW-1:0] user_of(input int i);
        return 64'h4444_3333_2222_0000 + 64'(pkt[i]) + (64'(i) << 48);
    endfunction

    function automatic logic [KW-1:0] keep_of(input int i);
        return KW'((beat[i] + i) % 15 + 1);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]          = (pkts_left[i] > 0) && !hold[i];
            s_axis_tdata[i*DW +: DW]  = data_of(i);
            s_axis_tkeep[i*KW +: KW]  = keep_of(i);
            s_axis_tuser[i*UW +: UW]  = user_of(i);
            s_axis_tlast[i]           = (beat[i] == len[i] - 1);
        end
    endtask

    task automatic start_pkts(input int i, input int n, input int l);
        pkts_left[i] = n;
        len[i]       = l;
        beat[i]      = 0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) begin
            if (pkts_left[i] > 0) return 1'b0;
        end
        return owner < 0;
    endfunction

    // One clock: check the pass-through, advance the model, check registered state.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        #1;
        exp_rdy = '0;
        if (owner >= 0) begin
            chk("m_tvalid", 64'(m_axis_tvalid), 64'(s_axis_tvalid[owner]));
            if (s_axis_tvalid[owner]) begin
                chk("m_tdata", 64'(m_axis_tdata), 64'(data_of(owner)));
                chk("m_tuser", m_axis_tuser, user_of(owner));
                chk("m_tkeep", 64'(m_axis_tkeep), 64'(keep_of(owner)));
                chk("m_tlast", 64'(m_axis_tlast), 64'(beat[owner] == len[owner] - 1));
            end
            if (m_axis_tready) exp_rdy = N'(1 << owner);
        end else begin
            chk("m_tvalid_idle", 64'(m_axis_tvalid), 64'(0));
        end
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));

        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                automatic int i = (ptr + k) % N;
                if (owner < 0 && s_axis_tvalid[i] && src_en[i] && arb_en) begin
                    owner    = i;
                    last_src = i;
                    grant_log.push_back(i);
                end
            end
        end else if (s_axis_tvalid[owner] && m_axis_tready) begin
            automatic int o = owner;
            xfer_cnt[o]++;
            if (beat[o] == len[o] - 1) begin
                cnt[o] = (cnt[o] + 1) % (1 << CW);
                ptr    = (o + 1) % N;
                owner  = -1;
                beat[o] = 0;
                pkt[o]++;
                pkts_left[o]--;
            end else begin
                beat[o]++;
            end
        end
        if (cnt_clr) begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
        end

        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("cur_src", 64'(cur_src), 64'(last_src));
        for (int i = 0; i < N; i++) begin
            chk("pkt_cnt", 64'(pkt_cnt[i*CW +: CW]), 64'(cnt[i]));
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 3) == 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
        if (toggle_mode) m_axis_tready = !m_axis_tready;
        drive();
    endtask

    task automatic run_until_idle(input int maxc);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!all_done() && c < maxc);
        chk("idle_timeout", 64'(c < maxc), 64'(1));
    endtask

    task automatic run_n(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic wait_beat(input int o, input int b, input int maxc);
        int c = 0;
        while (!(owner == o && beat[o] == b) && c < maxc) begin
            tick();
            c++;
        end
        chk("beat_timeout", 64'(c < maxc), 64'(1));
    endtask

    task automatic model_reset();
        owner = -1; ptr = 0; last_src = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; beat[i] = 0; len[i] = 1; pkts_left[i] = 0; hold[i] = 1'b0;
        end
    endtask

    initial begin
        int p0, n2, x2;
        rst = 1'b0; arb_en = 1'b1; src_en = '1; cnt_clr = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) begin pkt[i] = 0; xfer_cnt[i] = 0; end
        model_reset();
        drive();
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cur_src", 64'(cur_src), 64'(0));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Single source, two 128-beat packets.
        start_pkts(0, 2, 128); drive();
        run_until_idle(400);
        chk("single_cnt0", 64'(pkt_cnt[0 +: CW]), 64'(2));
        chk("single_beats", 64'(xfer_cnt[0]), 64'(256));

        // Fairness: all sources continuously valid.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        grant_log.delete(); p0 = ptr;
        for (int i = 0; i < N; i++) start_pkts(i, 2, 4);
        drive();
        run_until_idle(200);
        chk("fair_ngrants", 64'(grant_log.size()), 64'(8));
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            chk("fair_order", 64'(grant_log[k]), 64'((p0 + k) % N));
        end
        for (int i = 0; i < N; i++) chk("fair_cnt", 64'(pkt_cnt[i*CW +: CW]), 64'(2));

        // Backpressure: ready toggles every cycle during a 16-beat packet.
        x2 = xfer_cnt[2];
        start_pkts(2, 1, 16); drive();
        toggle_mode = 1'b1;
        run_until_idle(100);
        toggle_mode = 1'b0; m_axis_tready = 1'b1; drive();
        chk("bp_beats", 64'(xfer_cnt[2] - x2), 64'(16));

        // Disabled source is never granted.
        src_en = 4'b1011; grant_log.delete(); x2 = xfer_cnt[2];
        for (int i = 0; i < N; i++) start_pkts(i, 2, 3);
        drive();
        run_n(60);
        n2 = 0;
        foreach (grant_log[k]) if (grant_log[k] == 2) n2++;
        chk("en_src2_grants", 64'(n2), 64'(0));
        chk("en_src2_beats", 64'(xfer_cnt[2] - x2), 64'(0));
        chk("en_others_done", 64'(pkts_left[0] + pkts_left[1] + pkts_left[3]), 64'(0));
        pkts_left[2] = 0; src_en = '1; drive();
        run_n(2);

        // arb_en cleared mid-packet: the packet finishes, then no new grant.
        start_pkts(1, 1, 8); drive();
        wait_beat(1, 3, 20);
        arb_en = 1'b0;
        start_pkts(0, 1, 2); drive();
        run_n(15);
        chk("arb_src1_done", 64'(pkts_left[1]), 64'(0));
        chk("arb_src0_wait", 64'(pkts_left[0]), 64'(1));
        chk("arb_busy", 64'(busy), 64'(0));
        arb_en = 1'b1;
        run_until_idle(20);

        // Counter wrap with single-beat packets, then clear colliding with tlast.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        start_pkts(0, 15, 1); drive();
        run_until_idle(100);
        chk("cnt_max", 64'(pkt_cnt[0 +: CW]), 64'(15));
        start_pkts(0, 1, 1); drive();
        run_until_idle(10);
        chk("cnt_wrap", 64'(pkt_cnt[0 +: CW]), 64'(0));
        start_pkts(1, 1, 1); drive();
        wait_beat(1, 0, 10);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr_wins", 64'(pkt_cnt[1*CW +: CW]), 64'(0));
        chk("clr_done", 64'(pkts_left[1]), 64'(0));

        // Randomized traffic with random stalls and backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < N; i++) start_pkts(i, $urandom_range(1, 3), $urandom_range(1, 6));
        drive();
        run_until_idle(2000);
        rand_mode = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        drive();

        // Reset in the middle of a packet, pointer left at 2 beforehand.
        start_pkts(1, 1, 3); drive();
        run_until_idle(20);
        start_pkts(1, 1, 10); drive();
        wait_beat(1, 5, 20);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        model_reset();
        drive();
        @(posedge clk); #1 rst = 1'b0;
        grant_log.delete();
        start_pkts(1, 1, 2); start_pkts(3, 1, 2); drive();
        run_until_idle(20);
        chk("post_rst_ngrants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            chk("post_rst_first", 64'(grant_log[0]), 64'(1));
            chk("post_rst_src3", 64'(grant_log[1]), 64'(3));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
